// File: rtl/glitch_loader.sv
// glitch_loader: turns serial command frames (SYNC, N, N x 4 bytes, CSUM)
// into 32-bit command words for the glitch FIFO, then pads it to full.
// Ports: clk_in/rst (async, active-low), rx_data/rx_valid byte input,
//   glitch_ready/fifo_full/fifo_empty status, fifo_out/fifo_we/fifo_clr
//   FIFO write side, busy/done/err_code status outputs.
module glitch_loader #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        glitch_ready,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic [31:0] fifo_out,
    output logic        fifo_we,
    output logic        fifo_clr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_PAD,
        S_FLUSH
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  word_cnt, cnt_nx;
    logic [7:0]  csum, csum_nx;
    logic [31:0] asm_reg, asm_nx;
    logic [1:0]  byte_idx, idx_nx;
    logic [15:0] idle_cnt, idle_nx;
    logic [31:0] out_q, out_nx;
    logic        we_q, we_nx;
    logic [1:0]  err_q, err_nx;
    logic        pad_we;
    logic        clr_c;
    logic        done_c;
    logic        timed_out;
    logic [31:0] asm_shift;

    assign timed_out = (idle_cnt == TIMEOUT - 16'd1);
    assign asm_shift = {asm_reg[23:0], rx_data};

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= 8'd0;
            csum     <= 8'd0;
            asm_reg  <= 32'd0;
            byte_idx <= 2'd0;
            idle_cnt <= 16'd0;
            out_q    <= 32'd0;
            we_q     <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            state    <= state_nx;
            word_cnt <= cnt_nx;
            csum     <= csum_nx;
            asm_reg  <= asm_nx;
            byte_idx <= idx_nx;
            idle_cnt <= idle_nx;
            out_q    <= out_nx;
            we_q     <= we_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = word_cnt;
        csum_nx  = csum;
        asm_nx   = asm_reg;
        idx_nx   = byte_idx;
        idle_nx  = idle_cnt;
        out_nx   = out_q;
        we_nx    = 1'b0;
        err_nx   = err_q;
        pad_we   = 1'b0;
        clr_c    = 1'b0;
        done_c   = 1'b0;
        case (state)
            S_IDLE: begin
                idle_nx = 16'd0;
                if (rx_valid && rx_data == SYNC &&
                    glitch_ready && fifo_empty) begin
                    err_nx   = 2'd0;
                    state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    idle_nx = 16'd0;
                    if (rx_data == 8'd0) begin
                        err_nx   = 2'd3;
                        state_nx = S_FLUSH;
                    end else begin
                        cnt_nx   = rx_data;
                        csum_nx  = rx_data;
                        idx_nx   = 2'd0;
                        state_nx = S_DATA;
                    end
                end else if (timed_out) begin
                    err_nx   = 2'd2;
                    state_nx = S_FLUSH;
                end else begin
                    idle_nx = idle_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    idle_nx = 16'd0;
                    csum_nx = csum ^ rx_data;
                    asm_nx  = asm_shift;
                    idx_nx  = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (fifo_full) begin
                            err_nx   = 2'd3;
                            state_nx = S_FLUSH;
                        end else begin
                            out_nx = asm_shift;
                            we_nx  = 1'b1;
                            cnt_nx = word_cnt - 8'd1;
                            if (word_cnt == 8'd1)
                                state_nx = S_CSUM;
                        end
                    end
                end else if (timed_out) begin
                    err_nx   = 2'd2;
                    state_nx = S_FLUSH;
                end else begin
                    idle_nx = idle_cnt + 16'd1;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    idle_nx = 16'd0;
                    if (rx_data == csum) begin
                        // zero word = delay 0, width 0: executor no-op
                        out_nx   = 32'd0;
                        state_nx = S_PAD;
                    end else begin
                        err_nx   = 2'd1;
                        state_nx = S_FLUSH;
                    end
                end else if (timed_out) begin
                    err_nx   = 2'd2;
                    state_nx = S_FLUSH;
                end else begin
                    idle_nx = idle_cnt + 16'd1;
                end
            end
            S_PAD: begin
                // a full FIFO is what starts the executor
                if (fifo_full) begin
                    done_c   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    pad_we = 1'b1;
                end
            end
            S_FLUSH: begin
                clr_c    = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign fifo_out = out_q;
    assign fifo_we  = we_q | pad_we;
    assign fifo_clr = clr_c;
    assign done     = done_c;
    assign busy     = (state != S_IDLE);
    assign err_code = err_q;

endmodule

// File: tb/tb_glitch_loader.sv
// tb_glitch_loader: scoreboard bench for glitch_loader with a 4-deep
// FIFO model, directed frames and randomized frames.
module tb_glitch_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TO = 20;
    localparam int DEPTH = 4;
    localparam int K_WR = 0;
    localparam int K_CLR = 1;
    localparam int K_DONE = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        glitch_ready = 1'b1;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_out;
    logic        fifo_we;
    logic        fifo_clr;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    logic hold_ne = 1'b0;
    logic drain = 1'b0;
    int   fcnt = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   clr_cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    glitch_loader #(.SYNC(SYNC), .TIMEOUT(16'(TO))) dut (
        .clk_in(clk_in),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .glitch_ready(glitch_ready),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_out(fifo_out),
        .fifo_we(fifo_we),
        .fifo_clr(fifo_clr),
        .busy(busy),
        .done(done),
        .err_code(err_code)
    );

    always #5 clk_in = ~clk_in;

    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0) && !hold_ne;

    always @(posedge clk_in) cyc <= cyc + 1;

    // FIFO model: not affected by the loader's reset
    always @(posedge clk_in) begin
        if (drain || fifo_clr)
            fcnt <= 0;
        else if (fifo_we && fcnt < DEPTH)
            fcnt <= fcnt + 1;
    end

    function automatic void check(input string nm,
                                  input logic [31:0] act,
                                  input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endfunction

    function automatic void push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    function automatic void take(input int kind, input logic [31:0] val,
                                 input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_%s: got %h, expected no event", nm, val);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, 32'(kind), 32'(e.kind));
            check(nm, val, e.val);
        end
    endfunction

    // monitor: compares every FIFO write, flush and done against the queue
    always @(negedge clk_in) begin
        if (rst) begin
            if (fifo_we && !fifo_full)
                take(K_WR, fifo_out, "write");
            if (fifo_clr) begin
                clr_cyc = cyc;
                take(K_CLR, 32'(err_code), "flush_err");
            end
            if (done)
                take(K_DONE, 32'(err_code), "done_err");
        end
    end

    // reference: what a frame should produce, from the frame rules alone
    function automatic void model(input bq_t b, input int start);
        int n;
        int cnt;
        logic [7:0] x;
        logic [31:0] w;
        cnt = start;
        if (b.size() < 2) begin
            push(K_CLR, 32'd2);
            return;
        end
        n = int'(b[1]);
        if (n == 0) begin
            push(K_CLR, 32'd3);
            return;
        end
        x = b[1];
        for (int i = 0; i < n; i++) begin
            if (b.size() < 2 + 4 * (i + 1)) begin
                push(K_CLR, 32'd2);
                return;
            end
            w = {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]};
            x = x ^ b[2+4*i] ^ b[3+4*i] ^ b[4+4*i] ^ b[5+4*i];
            if (cnt == DEPTH) begin
                push(K_CLR, 32'd3);
                return;
            end
            push(K_WR, w);
            cnt++;
        end
        if (b.size() < 3 + 4 * n) begin
            push(K_CLR, 32'd2);
            return;
        end
        if (b[2+4*n] != x) begin
            push(K_CLR, 32'd1);
            return;
        end
        for (int i = cnt; i < DEPTH; i++)
            push(K_WR, 32'd0);
        push(K_DONE, 32'd0);
    endfunction

    task automatic send_byte(input logic [7:0] v);
        rx_data  = v;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic send_frame(input bq_t b, input int maxgap);
        foreach (b[i]) begin
            send_byte(b[i]);
            repeat ($urandom_range(0, maxgap)) @(negedge clk_in);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        if (k >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_drain: got %0d pending, expected 0",
                     nm, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic empty_fifo();
        drain = 1'b1;
        @(negedge clk_in);
        drain = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_out"}, fifo_out, 32'd0);
        check({nm, "_we"}, 32'(fifo_we), 32'd0);
        check({nm, "_clr"}, 32'(fifo_clr), 32'd0);
        check({nm, "_busy"}, 32'(busy), 32'd0);
        check({nm, "_done"}, 32'(done), 32'd0);
        check({nm, "_err"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int  n;
        logic [7:0] x;

        #1;
        check_zero("reset");
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);

        // valid single-word frame
        f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h05, 8'h02, 8'h16};
        model(f, 0);
        send_frame(f, 2);
        wait_idle("valid");
        check("valid_err", 32'(err_code), 32'd0);
        check("valid_fill", 32'(fcnt), 32'(DEPTH));
        empty_fifo();

        // bad checksum
        f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h05, 8'h02, 8'h17};
        model(f, 0);
        send_frame(f, 2);
        wait_idle("badsum");
        check("badsum_err", 32'(err_code), 32'd1);
        empty_fifo();

        // timeout after one complete word
        f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h07};
        model(f, 0);
        send_frame(f, 0);
        wait_idle("timeout");
        check("timeout_latency", 32'(clr_cyc - last_cyc), 32'(TO));
        check("timeout_err", 32'(err_code), 32'd2);
        empty_fifo();

        // overflow at the fifth word
        f = '{8'hA5, 8'h05};
        for (int i = 0; i < 20; i++)
            f.push_back(8'(i + 1));
        model(f, 0);
        send_frame(f, 1);
        wait_idle("overflow");
        check("overflow_err", 32'(err_code), 32'd3);
        empty_fifo();

        // zero count
        f = '{8'hA5, 8'h00};
        model(f, 0);
        send_frame(f, 1);
        wait_idle("zerocnt");
        check("zerocnt_err", 32'(err_code), 32'd3);

        // gating: executor busy, then FIFO not empty
        for (int g = 0; g < 2; g++) begin
            glitch_ready = (g != 0);
            hold_ne = (g != 0);
            send_byte(SYNC);
            glitch_ready = 1'b1;
            hold_ne = 1'b0;
            f = '{8'h01, 8'h00, 8'h10, 8'h05, 8'h02, 8'h16};
            foreach (f[i]) begin
                send_byte(f[i]);
                check("gate_busy", 32'(busy), 32'd0);
            end
            repeat (4) @(negedge clk_in);
            check("gate_fifo", 32'(fcnt), 32'd0);
        end

        // async reset mid-frame, after the first word landed
        f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h05, 8'h02};
        push(K_WR, 32'h00100502);
        send_frame(f, 0);
        repeat (2) @(negedge clk_in);
        check("prerst_busy", 32'(busy), 32'd1);
        check("prerst_out", fifo_out, 32'h00100502);
        #2 rst = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        check("midrst_kept", 32'(fcnt), 32'd1);
        check("midrst_q", 32'(exp_q.size()), 32'd0);
        empty_fifo();
        f = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h05, 8'h02, 8'h16};
        model(f, 0);
        send_frame(f, 2);
        wait_idle("postrst");
        check("postrst_err", 32'(err_code), 32'd0);
        empty_fifo();

        // randomized frames
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 4);
            f = '{SYNC, 8'(n)};
            x = 8'(n);
            for (int i = 0; i < 4 * n; i++) begin
                f.push_back(8'($urandom));
                x = x ^ f[f.size()-1];
            end
            if (n != 0) begin
                if ($urandom_range(0, 3) == 0)
                    x = x ^ 8'($urandom_range(1, 255));
                f.push_back(x);
            end
            if ($urandom_range(0, 7) == 0)
                while (f.size() > 1 && $urandom_range(0, 1) == 1)
                    void'(f.pop_back());
            model(f, 0);
            send_frame(f, 3);
            wait_idle("rand");
            check("rand_idle", 32'(busy), 32'd0);
            empty_fifo();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
